// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive front end: sampler state encoding,
// legal oversampling factors and the three-sample majority vote.
package uart_rx_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int PRESCALE_8       = 8;
   localparam int PRESCALE_16      = 16;
   localparam int PRESCALE_32      = 32;
   localparam int PRESCALE_DEFAULT = PRESCALE_16;

   function automatic logic majority3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_rx_edge_sampler_if.sv
// Signal bundle between the Rx controller/line side (master) and the edge
// sampler (slave).
interface uart_rx_edge_sampler_if #(
   parameter int PRESCALE_W = 6
);
   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic                  sampler_en;
   logic                  start_bit_detector;
   logic                  bit_tick;
   logic                  sampled_bit;
   logic [PRESCALE_W-1:0] edge_count;

   modport master (
      output rx_in, prescale, sampler_en,
      input  start_bit_detector, bit_tick, sampled_bit, edge_count
   );

   modport slave (
      input  rx_in, prescale, sampler_en,
      output start_bit_detector, bit_tick, sampled_bit, edge_count
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; both flops reset to
// the line idle level so no false edge appears on reset release.
module uart_rx_sync #(
   parameter logic RESET_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rx_sync_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_LEVEL;
         sync_q <= RESET_LEVEL;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
      end
   end

   assign rx_sync_o = sync_q;
endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART Rx front end: start-edge detection, per-bit oversampling counter,
// bit_tick generation and three-sample mid-bit majority vote.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | counter held at 0, watching for a falling edge on rx_sync
//   ST_RUN  | counting bit periods; exits on a tick with sampler_en low
module uart_rx_edge_sampler
   import uart_rx_pkg::*;
#(
   parameter int   PRESCALE_W = 6,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input logic              clk,
   input logic              rst,
   uart_rx_edge_sampler_if.slave sif
);
   logic                  rx_sync;
   logic                  rx_prev_q;
   logic [0:0]            state_q, state_d;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic [PRESCALE_W-1:0] ps_q, ps_d;
   logic                  start_q, start_d;
   logic                  sbit_q, sbit_d;
   logic [2:0]            vote_q, vote_d;
   logic [PRESCALE_W-1:0] mid, mid_m1, mid_p1, last;
   logic                  fall;
   logic                  tick;
   logic                  ps_legal;

   uart_rx_sync #(
      .RESET_LEVEL(IDLE_LEVEL)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .rx_i     (sif.rx_in),
      .rx_sync_o(rx_sync)
   );

   always_comb begin
      fall     = rx_prev_q & ~rx_sync;
      last     = ps_q - PRESCALE_W'(1);
      mid      = ps_q >> 1;
      mid_m1   = mid - PRESCALE_W'(1);
      mid_p1   = mid + PRESCALE_W'(1);
      tick     = (state_q == ST_RUN) && (cnt_q == last);
      ps_legal = (sif.prescale == PRESCALE_W'(PRESCALE_8))  ||
                 (sif.prescale == PRESCALE_W'(PRESCALE_16)) ||
                 (sif.prescale == PRESCALE_W'(PRESCALE_32));

      state_d = state_q;
      cnt_d   = cnt_q;
      ps_d    = ps_q;
      start_d = 1'b0;
      sbit_d  = sbit_q;
      vote_d  = vote_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (fall) begin
               state_d = ST_RUN;
               start_d = 1'b1;
               ps_d    = ps_legal ? sif.prescale : PRESCALE_W'(PRESCALE_DEFAULT);
            end
         end
         ST_RUN: begin
            cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
            if ((cnt_q == mid_m1) || (cnt_q == mid) || (cnt_q == mid_p1)) begin
               vote_d = {vote_q[1:0], rx_sync};
            end
            // The third capture joins the vote in the same cycle it is taken.
            if (cnt_q == mid_p1) begin
               sbit_d = majority3({vote_q[1:0], rx_sync});
            end
            if (tick && !sif.sampler_en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_prev_q <= IDLE_LEVEL;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ps_q      <= PRESCALE_W'(PRESCALE_DEFAULT);
         start_q   <= 1'b0;
         sbit_q    <= IDLE_LEVEL;
         vote_q    <= 3'b111;
      end else begin
         rx_prev_q <= rx_sync;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ps_q      <= ps_d;
         start_q   <= start_d;
         sbit_q    <= sbit_d;
         vote_q    <= vote_d;
      end
   end

   assign sif.start_bit_detector = start_q;
   assign sif.bit_tick           = tick;
   assign sif.sampled_bit        = sbit_q;
   assign sif.edge_count         = cnt_q;
endmodule

// File: doc/uart_rx_edge_sampler.md
Name: uart_rx_edge_sampler

Overview:
Front-end stage of the UART receiver, directly upstream of the Rx FSM controller.
- Synchronises the asynchronous serial line.
- Detects the start-bit falling edge.
- Counts oversampling clock cycles within each bit period.
- Majority-votes three mid-bit samples.
- Produces the bit_tick, start_bit_detector and sampled_bit signals that the controller and the deserialiser/parity/stop checkers consume.

Parameters:
PRESCALE_W, 6, width of the prescale input and the edge counter (must hold 32).
IDLE_LEVEL, 1'b1, line idle level; used as the reset value of the synchroniser and of sampled_bit.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous, active-high reset
rx_in  input  1  raw serial line, asynchronous to clk
prescale  input  PRESCALE_W  oversampling factor; legal values 8, 16, 32
sampler_en  input  1  sampler enable from the controller (block_enable_word[3])
start_bit_detector  output  1  one-cycle pulse on a detected start edge
bit_tick  output  1  one-cycle pulse in the last cycle of each bit period
sampled_bit  output  1  majority-voted value of the current bit
edge_count  output  PRESCALE_W  position within the current bit period

Behaviour:
Reset (async, active-high)
- Synchroniser flops and rx_prev = IDLE_LEVEL.
- state = IDLE, edge_count = 0, prescale_q = 16.
- start_bit_detector = 0, bit_tick = 0, sampled_bit = IDLE_LEVEL, vote register = 3'b111.

Synchroniser
- Two flops feed rx_sync; rx_prev holds rx_sync delayed one cycle.
- rx_in to rx_sync latency: 2 cycles.

State IDLE
- edge_count is held at 0; bit_tick = 0.
- On rx_prev==1 && rx_sync==0:
  - next cycle: state = RUN, start_bit_detector = 1 for exactly one cycle, edge_count = 0.
  - prescale_q latches prescale; any value other than 8/16/32 latches as 16.
- start_bit_detector therefore rises 3 cycles after rx_in falls.

State RUN
- edge_count increments by 1 each cycle.
- At edge_count == prescale_q-1, edge_count wraps to 0.
- bit_tick = (state==RUN && edge_count==prescale_q-1). It is a combinational decode of registered state, pulses once per bit period, and never fires in IDLE.
- Sampling, with mid = prescale_q>>1:
  - rx_sync is captured at edge_count = mid-1, mid and mid+1.
  - At the end of the mid+1 cycle, sampled_bit = majority of the three captures.
  - sampled_bit is visible from edge_count = mid+2 and held until the next update.
  - Examples: prescale 8 samples at 3,4,5 and updates at 6; prescale 16 samples at 7,8,9 and updates at 10.

RUN -> IDLE
- Taken on a bit_tick cycle with sampler_en == 0. That tick is still emitted.
- sampler_en == 0 at any other time is ignored. This covers the one-cycle controller lag after start detection and the controller's DONE state, which waits for a final tick.

Other conditions
- A falling edge during RUN is ignored.
- A falling edge in the same cycle as the RUN->IDLE exit is not detected; a fresh edge is required.
- A prescale change mid-frame has no effect until the next start edge.
- Reset mid-frame returns all state to reset values immediately.

Decomposition:
Shared package uart_rx_pkg:
- state encoding IDLE/RUN.
- constants PRESCALE_8/16/32 and PRESCALE_DEFAULT = 16.

Sub-module uart_rx_sync: the 2-flop synchroniser with parameterised reset level. Everything else stays in this block.

Test Plan:
1. Reset with rx_in = 1: sampled_bit = 1, edge_count = 0, no pulses. Drop rx_in to 0 (prescale 16): start_bit_detector is high exactly 3 cycles later for 1 cycle; bit_tick first fires 15 cycles after that.
2. Prescale 8, frame 0x55 (start + 8 data + stop) with sampler_en held high: 10 bit_ticks spaced 8 cycles apart; sampled_bit sequence 0,1,0,1,0,1,0,1,0,1.
3. Prescale 16, single-cycle glitch of 0 at sample position 8 within a 1 bit: sampled_bit stays 1. Two-cycle glitch at positions 8 and 9: sampled_bit = 0.
4. Prescale 32 running, sampler_en dropped mid-bit at edge_count 5: ticks continue; exit to IDLE only after the next tick. A further rx_in falling edge inside RUN produces no start_bit_detector.
5. Prescale = 12 (illegal): bit period is 16 cycles. Prescale changed to 8 mid-frame: period stays 16 until the next start edge, then becomes 8.
6. rst asserted at edge_count 9 of a data bit: all outputs immediately return to reset values. After release, the next falling edge is detected normally.
